// File: rtl/ps_pkg.sv
// Shared helpers for the pulse-swallow P/S word generator:
// width derivation, N split and Sigma-Delta sign extension.
package ps_pkg;

    typedef struct packed {
        logic [31:0] p;
        logic [31:0] s;
    } ps_split_t;

    function automatic int calc_n_width(input int p_w, input int s_w);
        return p_w + s_w;
    endfunction

    // P is the prescaler-cycle count (upper bits), S the swallow count (low bits)
    function automatic ps_split_t split_n(input logic [31:0] n, input int s_w);
        ps_split_t r;
        r.p = n >> s_w;
        r.s = n & ((32'd1 << s_w) - 32'd1);
        return r;
    endfunction

    function automatic logic signed [31:0] sext_ds(input logic [31:0] v, input int w);
        logic signed [31:0] t;
        t = $signed(v << (32 - w));
        return t >>> (32 - w);
    endfunction

endpackage

// File: rtl/ps_word_gen_clamp.sv
// Combinational signed ratio + offset add, clamp to [N_MIN, N_MAX], and clamp flag.
module ps_clamp
    import ps_pkg::*;
#(
    parameter int N_WIDTH  = 8,
    parameter int DS_WIDTH = 4,
    parameter int N_MIN    = 56,
    parameter int N_MAX    = 255
) (
    input  logic [N_WIDTH-1:0]  ratio,
    input  logic [DS_WIDTH-1:0] ds,
    output logic [N_WIDTH-1:0]  n,
    output logic                sat
);

    localparam int SW = N_WIDTH + 2;
    localparam logic signed [SW-1:0] MIN_S = SW'(N_MIN);
    localparam logic signed [SW-1:0] MAX_S = SW'(N_MAX);

    logic signed [31:0]   ds_ext;
    logic signed [SW-1:0] sum;
    logic                 lo;
    logic                 hi;
    logic                 unused_ext;

    // Two guard bits keep the sum signed and wrap-free at both 0 and 2**N_WIDTH
    always_comb begin
        ds_ext     = sext_ds(32'(ds), DS_WIDTH);
        unused_ext = ^ds_ext[31:SW];
        sum        = $signed({2'b00, ratio}) + $signed(ds_ext[SW-1:0]);
        lo         = sum < MIN_S;
        hi         = sum > MAX_S;
        sat        = lo | hi;
        n          = sum[N_WIDTH-1:0];
        if (lo) n = N_WIDTH'(N_MIN);
        else if (hi) n = N_WIDTH'(N_MAX);
    end

endmodule

// File: rtl/ps_word_gen.sv
// Frame-synchronous P/S word generator: double-buffered integer ratio, 2-stage
// pipeline from ld to ps_valid, clamp flags.
module ps_word_gen
    import ps_pkg::*;
#(
    parameter  int P_WIDTH  = 5,
    parameter  int S_WIDTH  = 3,
    parameter  int DS_WIDTH = 4,
    parameter  int N_MIN    = 56,
    parameter  int N_MAX    = 255,
    parameter  int N_RESET  = 64,
    localparam int N_WIDTH  = calc_n_width(P_WIDTH, S_WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_WIDTH-1:0]  int_in,
    input  logic                int_wr,
    input  logic [DS_WIDTH-1:0] ds_in,
    input  logic                ds_en,
    input  logic                ld,
    output logic                ds_ack,
    output logic [P_WIDTH-1:0]  Pi,
    output logic [S_WIDTH-1:0]  Si,
    output logic [N_WIDTH-1:0]  n_out,
    output logic                ps_valid,
    output logic                sat,
    output logic                sat_sticky,
    input  logic                clr_err
);

    if (!(N_MIN <= N_RESET && N_RESET <= N_MAX && N_MAX < (1 << N_WIDTH))) begin : g_chk
        $error("ps_word_gen: require N_MIN <= N_RESET <= N_MAX < 2**N_WIDTH");
    end

    localparam logic [N_WIDTH-1:0] N_RST = N_WIDTH'(N_RESET);

    logic [N_WIDTH-1:0]  shadow_q, shadow_d;
    logic [N_WIDTH-1:0]  active_q, active_d;
    logic [N_WIDTH-1:0]  ratio_sel;
    logic [DS_WIDTH-1:0] ds_q, ds_d;
    logic [1:0]          vld_q, vld_d;
    logic [N_WIDTH-1:0]  n_q, n_d;
    logic                sat_q, sat_d;
    logic                sticky_q, sticky_d;
    logic [N_WIDTH-1:0]  clamp_n;
    logic                clamp_sat;
    ps_split_t           sp;
    logic                unused_split;

    // Stage 1 is active_q + ds_q; the clamp resolves it into stage 2
    ps_clamp #(
        .N_WIDTH (N_WIDTH),
        .DS_WIDTH(DS_WIDTH),
        .N_MIN   (N_MIN),
        .N_MAX   (N_MAX)
    ) u_clamp (
        .ratio(active_q),
        .ds   (ds_q),
        .n    (clamp_n),
        .sat  (clamp_sat)
    );

    always_comb begin
        ratio_sel = int_wr ? int_in : shadow_q;
        shadow_d  = ratio_sel;
        active_d  = ld ? ratio_sel : active_q;
        ds_d      = ds_q;
        if (ld) ds_d = ds_en ? ds_in : '0;
        vld_d     = {vld_q[0], ld};
        n_d       = vld_q[0] ? clamp_n : n_q;
        sat_d     = vld_q[0] ? clamp_sat : sat_q;
        // Set beats clear when both land on the same edge
        sticky_d  = (vld_q[0] & clamp_sat) | (sticky_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= N_RST;
            active_q <= N_RST;
            ds_q     <= '0;
            vld_q    <= '0;
            n_q      <= N_RST;
            sat_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            ds_q     <= ds_d;
            vld_q    <= vld_d;
            n_q      <= n_d;
            sat_q    <= sat_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin
        sp           = split_n(32'(n_q), S_WIDTH);
        Pi           = sp.p[P_WIDTH-1:0];
        Si           = sp.s[S_WIDTH-1:0];
        unused_split = ^{sp.p[31:P_WIDTH], sp.s[31:S_WIDTH]};
    end

    assign ds_ack     = vld_q[0];
    assign ps_valid   = vld_q[1];
    assign n_out      = n_q;
    assign sat        = sat_q;
    assign sat_sticky = sticky_q;

endmodule
